aes_inv_round_iter: RTL and testbench
=====================================

# aes_inv_round_iter

Iterative AES-128 inverse-round engine for the decryption datapath. It sits directly upstream of the final decryption round stage. It accepts a 128-bit ciphertext block and applies the initial AddRoundKey with round key 10. It then runs nine full inverse rounds (rounds 9..1), one per clock, and hands the resulting state to the final round stage, which applies InvSubBytes, InvShiftRows and AddRoundKey with round key 0.

## Interface
Parameters:
- NR, 10, number of AES rounds; fixed for AES-128, not user-overridable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  ciphertext block present on in_data.
- in_ready  out  1  engine can accept a block this cycle.
- in_data  in  128  ciphertext; byte [127:120] = row0/col0, column-major.
- key_idx  out  4  index of the round key required this cycle (0..10).
- rkey  in  128  round key key_idx, returned combinationally in the same cycle by the external key store.
- out_valid  out  1  out_data holds a finished state for the final round stage.
- out_ready  in  1  final round stage consumes out_data.
- out_data  out  128  state after inverse round 1; this is the datain of the final round stage.

## Operation
FSM states: IDLE, ROUND, DONE.
- IDLE: in_ready=1 and key_idx=4'hA.
  - On in_valid: st <= in_data ^ rkey, rnd <= 9, go to ROUND.
- ROUND: key_idx=rnd. Each cycle: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rkey), rnd <= rnd-1.
  - When rnd==1 this cycle, go to DONE instead of decrementing further.
- DONE: out_valid=1, key_idx=4'h0, out_data=st, held stable.
  - On out_ready: go to IDLE.
- InvShiftRows: out[r][c] = in[r][(c-r) mod 4], so row r is rotated right by r bytes.
- InvSubBytes: 16 inverse S-box lookups.
- InvMixColumns: per column, matrix {0e,0b,0d,09} circulant over GF(2^8) with polynomial 0x11B.
- in_valid is ignored outside IDLE; no buffering, no overflow.
- out_ready is ignored outside DONE.
- rnd is a 4-bit counter and never wraps below 1.

## Timing
- Reset values (async, immediate): FSM=IDLE, rnd=0, st=0, so out_data=0 and out_valid=0. in_ready is forced 0 while rst is high.
- Accept edge E0. Round edges E1..E9. out_valid is high from after E9 until the handshake edge.
- Minimum period between accepts: 11 cycles (accept, 9 rounds, DONE with out_ready=1), then IDLE.
- key_idx sequence per block: A, 9, 8, …, 1, 0.
- rkey must be valid in the same cycle as key_idx; the path through rkey is combinational into st.
- Reset mid-ROUND or mid-DONE: the block is discarded and the engine returns to IDLE with st=0. No partial output is produced.
- No ready-to-valid combinational paths:
  - in_ready depends only on FSM and rst.
  - out_valid depends only on FSM.

## Structure
- Shared package aes_pkg holds:
  - the FSM state enum;
  - the NR constant;
  - KEY_IDX_FIRST=4'hA and KEY_IDX_LAST=4'h0;
  - GF(2^8) helper functions xtime and gmul by 09/0b/0d/0e.
- Sub-module aes_inv_mixcol is natural: one 32-bit column in, one 32-bit column out, combinational, instantiated 4 times.
- Reuse the existing rev_aes_sbox, 16 instances.
- Top module holds the FSM, the round counter and the st register.

## Test plan
- FIPS-197 C.1 vector.
  - Stimulus: in_data=69c4e0d86a7b0430d8cdb78070b4c55a, bench supplies the key schedule for key 000102…0f.
  - Required: st=7ad5fda789ef4e272bca100b3d9ff59f after E0.
  - Required: out_data=6353e08c0960e104cd70b751bacad0e7 with out_valid after E9.
  - Required: key_idx sequence A,9,…,1,0.
- Backpressure: hold out_ready=0 for 20 cycles in DONE. Required: out_valid and out_data stable, in_ready=0; handshake on the first out_ready=1, then IDLE.
- Busy drop: pulse in_valid with a second block at E3. Required: it is ignored, the first result is unchanged, and in_ready=0 throughout.
- Reset mid-operation: assert rst at E5. Required: out_valid=0, out_data=0, in_ready=0 during reset. After release, the C.1 vector completes correctly.
- Back-to-back: two blocks with out_ready tied 1. Required: accepts 11 cycles apart, each output matches a software reference model.
- Random regression: 1000 random keys and plaintexts, encrypted by the model. Required: out_data equals the model state before the final inverse round.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES decryption types, constants and GF(2^8) constant multipliers.
package aes_pkg;

  localparam int NR = 10;
  localparam logic [3:0] KEY_IDX_FIRST = 4'hA;
  localparam logic [3:0] KEY_IDX_LAST  = 4'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul09(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul0b(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul0d(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/aes_inv_mixcol.sv
// InvMixColumns on one 32-bit column; byte [31:24] is row 0.
module aes_inv_mixcol
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign col_out = {
    gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3),
    gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3),
    gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3),
    gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3)
  };

endmodule

// File: rtl/rev_aes_sbox.sv
// AES inverse S-box, one byte, purely combinational lookup.
module rev_aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign dout = INV_SBOX[din];

endmodule

// File: rtl/aes_inv_round_iter.sv
// Iterative AES-128 decryption: initial AddRoundKey(10) then inverse rounds 9..1,
// one per clock; the result feeds the separate final-round stage.
module aes_inv_round_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   key_idx,
  input  logic [127:0] rkey,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  state_t       state_reg, state_next;
  logic [3:0]   rnd_reg;
  logic [127:0] st_reg;
  logic [127:0] shifted, subbed, keyed, round_out;

  // Bytes are column-major: byte k sits at row k%4, column k/4.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
      assign shifted[127-8*gi -: 8] = st_reg[127-8*SRC -: 8];
      rev_aes_sbox u_sbox (
        .din  (shifted[127-8*gi -: 8]),
        .dout (subbed[127-8*gi -: 8])
      );
    end
  endgenerate

  assign keyed = subbed ^ rkey;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      aes_inv_mixcol u_mixcol (
        .col_in  (keyed[127-32*gi -: 32]),
        .col_out (round_out[127-32*gi -: 32])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_reg <= 4'd0;
      st_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            st_reg  <= in_data ^ rkey;
            rnd_reg <= 4'(NR - 1);
          end
        end
        ROUND: begin
          st_reg <= round_out;
          // The counter parks at 1 on the last round rather than reaching 0.
          if (rnd_reg != 4'd1) begin
            rnd_reg <= rnd_reg - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = ROUND;
      ROUND:   if (rnd_reg == 4'd1) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    key_idx   = KEY_IDX_FIRST;
    case (state_reg)
      IDLE: begin
        in_ready = ~rst;
        key_idx  = KEY_IDX_FIRST;
      end
      ROUND:   key_idx = rnd_reg;
      DONE: begin
        out_valid = 1'b1;
        key_idx   = KEY_IDX_LAST;
      end
      default: ;
    endcase
  end

  assign out_data = st_reg;

endmodule

// File: tb/tb_aes_inv_round_iter.sv
// Self-checking bench: byte-level AES-128 encryption model supplies ciphertexts and
// the expected state after inverse round 1; the bench also acts as the key store.
module tb_aes_inv_round_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [3:0]   key_idx;
  logic [127:0] rkey;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  int unsigned last_acc = 0;

  logic [7:0]   sbox_fwd [256];
  logic [127:0] rk_tb [11];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rkey = (key_idx <= 4'd10) ? rk_tb[key_idx] : '0;

  aes_inv_round_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key_idx   (key_idx),
    .rkey      (rkey),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // Forward S-box from its definition: GF inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_fwd[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_fwd[t[31:24]], sbox_fwd[t[23:16]], sbox_fwd[t[15:8]], sbox_fwd[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = gf_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tb[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Encrypts pt with rk_tb; mid is the state after round 1 ShiftRows.
  task automatic encrypt(input logic [127:0] pt, output logic [127:0] ct, output logic [127:0] mid);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    mid = '0;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk_tb[0][127-8*k -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox_fwd[s[k]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[c*4+r] = t[((c + r) % 4) * 4 + r];
      if (rd == 1)
        for (int k = 0; k < 16; k++) mid[127-8*k -: 8] = s[k];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
          s[4*c+3] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk_tb[rd][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) ct[127-8*k -: 8] = s[k];
  endtask

  // One block from accept to handshake; called and returns on a falling edge.
  task automatic run_block(input string name, input logic [127:0] ct, input logic [127:0] exp_st0,
                           input logic [127:0] exp_out, input int hold, input int pulse_idx,
                           input bit tie);
    int waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); @(negedge clk);
      waited++;
    end
    if (!in_ready) check("accept_timeout", 128'(in_ready), 128'(1'b1));
    check("key_idx_first", 128'(key_idx), 128'(4'hA));
    last_acc = cyc;
    in_valid = 1'b1;
    in_data  = ct;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("st_after_e0", out_data, exp_st0);
    for (int i = 9; i >= 1; i--) begin
      check("key_idx_round", 128'(key_idx), 128'(i));
      check("in_ready_busy", 128'(in_ready), 128'(1'b0));
      check("out_valid_busy", 128'(out_valid), 128'(1'b0));
      if (i == pulse_idx) begin
        in_valid = 1'b1;
        in_data  = ~ct;
      end
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
    end
    check("out_valid_done", 128'(out_valid), 128'(1'b1));
    check("key_idx_last", 128'(key_idx), 128'(4'h0));
    check("out_data", out_data, exp_out);
    check("in_ready_done", 128'(in_ready), 128'(1'b0));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      check("hold_out_valid", 128'(out_valid), 128'(1'b1));
      check("hold_out_data", out_data, exp_out);
      check("hold_in_ready", 128'(in_ready), 128'(1'b0));
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    if (!tie) out_ready = 1'b0;
    check("hs_out_valid", 128'(out_valid), 128'(1'b0));
    check("hs_in_ready", 128'(in_ready), 128'(1'b1));
    $display("block %s: accepted at cycle %0d ct=%h out=%h", name, last_acc, ct, out_data);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] key, pt, ct, mid;
    int unsigned  prev_acc;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_ST0 = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] C1_OUT = 128'h6353e08c0960e104cd70b751bacad0e7;

    build_sbox();
    expand_key(C1_KEY);

    #3;
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_out_data", out_data, 128'h0);
    check("rst_in_ready", 128'(in_ready), 128'(1'b0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 128'(in_ready), 128'(1'b1));
    check("idle_key_idx", 128'(key_idx), 128'(4'hA));
    @(negedge clk);

    // C.1 vector with a busy-time pulse at E3 and 20 cycles of backpressure.
    run_block("c1_busy_bp", C1_CT, C1_ST0, C1_OUT, 20, 7, 1'b0);

    // Reset asserted just after E5 discards the block.
    check("pre_rst_ready", 128'(in_ready), 128'(1'b1));
    last_acc = cyc;
    in_valid = 1'b1;
    in_data  = C1_CT;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(1'b0));
    check("midrst_out_data", out_data, 128'h0);
    check("midrst_in_ready", 128'(in_ready), 128'(1'b0));
    repeat (2) begin
      @(negedge clk);
      check("midrst_in_ready_hold", 128'(in_ready), 128'(1'b0));
    end
    rst = 1'b0;
    #1;
    check("postrst_in_ready", 128'(in_ready), 128'(1'b1));
    check("postrst_out_valid", 128'(out_valid), 128'(1'b0));
    $display("block c1_reset: discarded by reset after E5");
    @(negedge clk);
    run_block("c1_after_rst", C1_CT, C1_ST0, C1_OUT, 1, 0, 1'b0);

    // Back-to-back with out_ready tied high.
    out_ready = 1'b1;
    prev_acc  = 0;
    for (int b = 0; b < 2; b++) begin
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      encrypt(pt, ct, mid);
      run_block("b2b", ct, ct ^ rk_tb[10], mid, 0, 0, 1'b1);
      if (b == 1) check("b2b_gap", 128'(last_acc - prev_acc), 128'(11));
      prev_acc = last_acc;
    end
    out_ready = 1'b0;

    // Random regression: fresh key and plaintext per block.
    for (int n = 0; n < 1000; n++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand_key(key);
      encrypt(pt, ct, mid);
      run_block("rand", ct, ct ^ rk_tb[10], mid, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 9)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
